// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order completion via two CDB ports, single in-order commit.
// Optional same-cycle CDB operand forwarding is enabled with ROB_CDB_BYPASS_EN.
module rob_param #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ID_W  = $clog2(DEPTH),
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [1:0]      issue_kind,
    input  logic [4:0]      issue_rd,
    input  logic [XLEN-1:0] issue_pc,
    input  logic            issue_pred_taken,
    input  logic [XLEN-1:0] issue_target,
    output logic [ID_W-1:0] issue_tag,
    input  logic [ID_W-1:0] src1_tag,
    input  logic [ID_W-1:0] src2_tag,
    output logic            src1_ready,
    output logic            src2_ready,
    output logic [XLEN-1:0] src1_val,
    output logic [XLEN-1:0] src2_val,
    input  logic            cdb0_valid,
    input  logic [ID_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0] cdb0_val,
    input  logic            cdb1_valid,
    input  logic [ID_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0] cdb1_val,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_val,
    output logic [ID_W-1:0] commit_tag,
    output logic            store_commit,
    output logic [ID_W-1:0] store_tag,
    output logic            bp_update,
    output logic [XLEN-1:0] bp_pc,
    output logic            bp_taken,
    output logic            flush_out,
    output logic [XLEN-1:0] flush_pc,
    output logic            exit_out,
    output logic [ID_W:0]   count
);

    localparam int unsigned CNT_W = ID_W + 1;

    typedef enum logic [1:0] {
        K_REG    = 2'd0,
        K_BRANCH = 2'd1,
        K_STORE  = 2'd2,
        K_EXIT   = 2'd3
    } kind_t;

    logic [ID_W-1:0]  head;
    logic [ID_W-1:0]  tail;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    kind_t            e_kind   [DEPTH];
    logic [4:0]       e_rd     [DEPTH];
    logic [XLEN-1:0]  e_pc     [DEPTH];
    logic             e_pred   [DEPTH];
    logic [XLEN-1:0]  e_target [DEPTH];
    logic [XLEN-1:0]  e_val    [DEPTH];

    logic commit_fire;
    logic mispredict;
    logic issue_fire;
    logic cdb_en;

    // Control decisions, all derived from registered state plus this cycle's requests
    always_comb begin
        issue_ready = (count != CNT_W'(DEPTH)) && !flush_out;
        issue_tag   = tail;
        commit_fire = valid[head] && ready[head];
        mispredict  = commit_fire && (e_kind[head] == K_BRANCH) && (e_val[head][0] != e_pred[head]);
        issue_fire  = issue_valid && issue_ready && !mispredict;
        cdb_en      = !flush_out && !mispredict;
    end

    // Operand lookup; port 0 takes priority over port 1 when forwarding
    always_comb begin
        src1_ready = valid[src1_tag] && ready[src1_tag];
        src1_val   = e_val[src1_tag];
        src2_ready = valid[src2_tag] && ready[src2_tag];
        src2_val   = e_val[src2_tag];
`ifdef ROB_CDB_BYPASS_EN
        if (valid[src1_tag] && cdb0_valid && (cdb0_tag == src1_tag)) begin
            src1_ready = 1'b1;
            src1_val   = cdb0_val;
        end else if (valid[src1_tag] && cdb1_valid && (cdb1_tag == src1_tag)) begin
            src1_ready = 1'b1;
            src1_val   = cdb1_val;
        end
        if (valid[src2_tag] && cdb0_valid && (cdb0_tag == src2_tag)) begin
            src2_ready = 1'b1;
            src2_val   = cdb0_val;
        end else if (valid[src2_tag] && cdb1_valid && (cdb1_tag == src2_tag)) begin
            src2_ready = 1'b1;
            src2_val   = cdb1_val;
        end
`endif
    end

    // Entry storage, pointers, retire pulses; later assignments override earlier ones
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_val   <= '0;
            commit_tag   <= '0;
            store_commit <= 1'b0;
            store_tag    <= '0;
            bp_update    <= 1'b0;
            bp_pc        <= '0;
            bp_taken     <= 1'b0;
            flush_out    <= 1'b0;
            flush_pc     <= '0;
            exit_out     <= 1'b0;
        end else if (rdy_in) begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            bp_update    <= 1'b0;
            flush_out    <= 1'b0;

            // Port 1 first so port 0 wins a same-tag collision
            if (cdb_en && cdb1_valid && valid[cdb1_tag]) begin
                ready[cdb1_tag] <= 1'b1;
                e_val[cdb1_tag] <= cdb1_val;
            end
            if (cdb_en && cdb0_valid && valid[cdb0_tag]) begin
                ready[cdb0_tag] <= 1'b1;
                e_val[cdb0_tag] <= cdb0_val;
            end

            if (commit_fire) begin
                valid[head] <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + ID_W'(1);
                unique case (e_kind[head])
                    K_REG: begin
                        if (e_rd[head] != 5'd0) begin
                            commit_valid <= 1'b1;
                            commit_rd    <= e_rd[head];
                            commit_val   <= e_val[head];
                            commit_tag   <= head;
                        end
                    end
                    K_BRANCH: begin
                        bp_update <= 1'b1;
                        bp_pc     <= e_pc[head];
                        bp_taken  <= e_val[head][0];
                    end
                    K_STORE: begin
                        store_commit <= 1'b1;
                        store_tag    <= head;
                    end
                    K_EXIT: exit_out <= 1'b1;
                endcase
            end

            if (issue_fire) begin
                e_kind[tail]   <= kind_t'(issue_kind);
                e_rd[tail]     <= issue_rd;
                e_pc[tail]     <= issue_pc;
                e_pred[tail]   <= issue_pred_taken;
                e_target[tail] <= issue_target;
                valid[tail]    <= 1'b1;
                ready[tail]    <= 1'b0;
                tail           <= tail + ID_W'(1);
            end

            count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);

            // Wrong-path recovery: drop every in-flight entry and redirect fetch
            if (mispredict) begin
                valid     <= '0;
                ready     <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                flush_out <= 1'b1;
                flush_pc  <= e_val[head][0] ? e_target[head] : e_pc[head] + XLEN'(4);
            end
        end
    end

endmodule
